// File: rtl/rs_dsp_mac_pkg.sv
// Shared widths, DSP constants and sequencer state encoding
// for the RS_DSP_MULTADD dot-product sequencer.
package rs_dsp_mac_pkg;

  localparam int A_W = 20;
  localparam int B_W = 18;
  localparam int Z_W = 38;

  localparam logic [2:0] FEEDBACK_ACC = 3'b000;
  localparam logic [5:0] ACC_FIR_ZERO = 6'd0;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUTPUT
  } state_t;

endpackage

// File: rtl/rs_dsp_mac_drain_timer.sv
// Loadable down-counter; done is high once 1+DSP_LATENCY edges
// have passed since load (the load edge counts as the first).
// Ports: clk, lreset (async low), load, done.
module rs_dsp_mac_drain_timer #(
  parameter int DSP_LATENCY = 1
) (
  input  logic clk,
  input  logic lreset,
  input  logic load,
  output logic done
);

  logic [2:0] cnt;

  always_ff @(posedge clk or negedge lreset) begin
    if (!lreset) begin
      cnt <= 3'd0;
    end else if (load) begin
      cnt <= 3'(DSP_LATENCY);
    end else if (cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign done = (cnt == 3'd0);

endmodule

// File: rtl/rs_dsp_mac_sequencer.sv
// Streams (a,b,sub) beats into an RS_DSP_MULTADD, sequences load_acc,
// waits out DSP latency and returns one dot product per vector.
// Ports: s_* operand stream in, dsp_* primitive pins, m_* result out.
module rs_dsp_mac_sequencer
  import rs_dsp_mac_pkg::*;
#(
  parameter int DSP_LATENCY = 1,
  parameter int MAX_LEN     = 1024,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             lreset,
  input  logic             cfg_unsigned_a,
  input  logic             cfg_unsigned_b,
  input  logic [5:0]       cfg_shift,
  input  logic             cfg_round,
  input  logic             cfg_sat,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [A_W-1:0]   s_a,
  input  logic [B_W-1:0]   s_b,
  input  logic             s_sub,
  input  logic             s_last,
  output logic [A_W-1:0]   dsp_a,
  output logic [B_W-1:0]   dsp_b,
  output logic [2:0]       dsp_feedback,
  output logic [5:0]       dsp_acc_fir,
  output logic             dsp_load_acc,
  output logic             dsp_unsigned_a,
  output logic             dsp_unsigned_b,
  output logic             dsp_saturate,
  output logic [5:0]       dsp_shift_right,
  output logic             dsp_round,
  output logic             dsp_subtract,
  input  logic [Z_W-1:0]   dsp_z,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [Z_W-1:0]   m_z,
  output logic [CNT_W-1:0] m_count,
  output logic             m_trunc
);

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic trunc_q;
  logic first, accept, last_beat;
  logic done, capture;

  assign dsp_feedback = FEEDBACK_ACC;
  assign dsp_acc_fir  = ACC_FIR_ZERO;

  assign first  = (state_q == IDLE);
  assign accept = s_valid && s_ready;
  assign cnt_nx = first ? CNT_W'(1)
                        : cnt_q + CNT_W'(1);

  // Hitting MAX_LEN ends the vector even without s_last.
  assign last_beat = accept &&
    (s_last || cnt_nx == CNT_W'(MAX_LEN));

  assign capture = (state_q == DRAIN) && done;

  rs_dsp_mac_drain_timer #(
    .DSP_LATENCY(DSP_LATENCY)
  ) u_timer (
    .clk   (clk),
    .lreset(lreset),
    .load  (last_beat),
    .done  (done)
  );

  always_ff @(posedge clk or negedge lreset) begin
    if (!lreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    unique case (state_q)
      IDLE, ACCUM: begin
        s_ready = 1'b1;
        if (last_beat)   state_d = DRAIN;
        else if (accept) state_d = ACCUM;
      end
      DRAIN: begin
        if (done) state_d = OUTPUT;
      end
      OUTPUT: begin
        m_valid = 1'b1;
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand pins: a bubble drives a zero product with
  // load_acc=1 so the accumulator holds its value.
  always_ff @(posedge clk or negedge lreset) begin
    if (!lreset) begin
      dsp_a        <= '0;
      dsp_b        <= '0;
      dsp_subtract <= 1'b0;
      dsp_load_acc <= 1'b1;
    end else if (accept) begin
      dsp_a        <= s_a;
      dsp_b        <= s_b;
      dsp_subtract <= s_sub;
      dsp_load_acc <= !first;
    end else begin
      dsp_a        <= '0;
      dsp_b        <= '0;
      dsp_subtract <= 1'b0;
      dsp_load_acc <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge lreset) begin
    if (!lreset) begin
      dsp_unsigned_a  <= 1'b0;
      dsp_unsigned_b  <= 1'b0;
      dsp_saturate    <= 1'b0;
      dsp_shift_right <= 6'd0;
      dsp_round       <= 1'b0;
    end else if (accept && first) begin
      dsp_unsigned_a  <= cfg_unsigned_a;
      dsp_unsigned_b  <= cfg_unsigned_b;
      dsp_saturate    <= cfg_sat;
      dsp_shift_right <= cfg_shift;
      dsp_round       <= cfg_round;
    end
  end

  always_ff @(posedge clk or negedge lreset) begin
    if (!lreset) begin
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else if (accept) begin
      cnt_q <= cnt_nx;
      if (last_beat) trunc_q <= !s_last;
    end
  end

  always_ff @(posedge clk or negedge lreset) begin
    if (!lreset) begin
      m_z     <= '0;
      m_count <= '0;
      m_trunc <= 1'b0;
    end else if (capture) begin
      m_z     <= dsp_z;
      m_count <= cnt_q;
      m_trunc <= trunc_q;
    end
  end

endmodule

// File: tb/tb_rs_dsp_mac_sequencer.sv
// Scoreboard bench: sequencer paired with a behavioral
// MULTIPLY_ADD_SUB DSP model (latency 1, no shift/round/sat).
module tb_rs_dsp_mac_sequencer;

  localparam int L  = 1;
  localparam int ML = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic lreset;
  logic cfg_unsigned_a, cfg_unsigned_b;
  logic [5:0] cfg_shift;
  logic cfg_round, cfg_sat;
  logic s_valid, s_ready;
  logic [19:0] s_a;
  logic [17:0] s_b;
  logic s_sub, s_last;
  logic [19:0] dsp_a;
  logic [17:0] dsp_b;
  logic [2:0] dsp_feedback;
  logic [5:0] dsp_acc_fir;
  logic dsp_load_acc, dsp_unsigned_a, dsp_unsigned_b;
  logic dsp_saturate, dsp_round, dsp_subtract;
  logic [5:0] dsp_shift_right;
  logic [37:0] dsp_z;
  logic m_valid, m_ready;
  logic [37:0] m_z;
  logic [CW-1:0] m_count;
  logic m_trunc;

  always #5 clk = ~clk;

  rs_dsp_mac_sequencer #(
    .DSP_LATENCY(L), .MAX_LEN(ML), .CNT_W(CW)
  ) dut (
    .clk(clk), .lreset(lreset),
    .cfg_unsigned_a(cfg_unsigned_a),
    .cfg_unsigned_b(cfg_unsigned_b),
    .cfg_shift(cfg_shift), .cfg_round(cfg_round),
    .cfg_sat(cfg_sat),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .s_sub(s_sub), .s_last(s_last),
    .dsp_a(dsp_a), .dsp_b(dsp_b),
    .dsp_feedback(dsp_feedback), .dsp_acc_fir(dsp_acc_fir),
    .dsp_load_acc(dsp_load_acc),
    .dsp_unsigned_a(dsp_unsigned_a),
    .dsp_unsigned_b(dsp_unsigned_b),
    .dsp_saturate(dsp_saturate),
    .dsp_shift_right(dsp_shift_right),
    .dsp_round(dsp_round), .dsp_subtract(dsp_subtract),
    .dsp_z(dsp_z),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_z(m_z), .m_count(m_count), .m_trunc(m_trunc)
  );

  // Behavioral DSP: accumulator updates one edge after operands.
  logic [37:0] acc = '0;

  function automatic logic [37:0] prod(
    input logic [19:0] a, input logic [17:0] b,
    input logic ua, input logic ub);
    logic [37:0] pa, pb;
    pa = ua ? {18'd0, a} : {{18{a[19]}}, a};
    pb = ub ? {20'd0, b} : {{20{b[17]}}, b};
    return pa * pb;
  endfunction

  always @(posedge clk) begin
    logic [37:0] p;
    p = prod(dsp_a, dsp_b, dsp_unsigned_a, dsp_unsigned_b);
    if (!dsp_load_acc) acc <= dsp_subtract ? -p : p;
    else acc <= dsp_subtract ? acc - p : acc + p;
  end

  assign dsp_z = acc;

  typedef struct packed {
    logic [37:0]   z;
    logic [CW-1:0] cnt;
    logic          trunc;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (lreset === 1'b1 && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_result: got m_z %0h, expected none",
                 m_z);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("m_z", 64'(m_z), 64'(e.z));
        chk("m_count", 64'(m_count), 64'(e.cnt));
        chk("m_trunc", 64'(m_trunc), 64'(e.trunc));
      end
    end
  end

  task automatic push(input logic [37:0] z,
                      input int cnt, input logic tr);
    exp_t e;
    e.z = z;
    e.cnt = CW'(cnt);
    e.trunc = tr;
    exp_q.push_back(e);
  endtask

  // Called just after a posedge; returns 1ns after accept edge.
  task automatic send(input logic [19:0] a, input logic [17:0] b,
                      input logic sub, input logic last);
    int n;
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    s_sub = sub;
    s_last = last;
    n = 0;
    #1;
    while (!s_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!s_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL s_ready_timeout: got 0, expected 1");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_sub = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL result_timeout: got %0d pending, expected 0",
               exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  logic [37:0] neg32;

  initial begin
    lreset = 1'b0;
    cfg_unsigned_a = 1'b0;
    cfg_unsigned_b = 1'b0;
    cfg_shift = 6'd0;
    cfg_round = 1'b0;
    cfg_sat = 1'b0;
    s_valid = 1'b0;
    s_a = '0;
    s_b = '0;
    s_sub = 1'b0;
    s_last = 1'b0;
    m_ready = 1'b1;
    neg32 = -38'sd32;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_load_acc", 64'(dsp_load_acc), 64'd1);
    chk("rst_dsp_a", 64'(dsp_a), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_feedback", 64'(dsp_feedback), 64'd0);
    chk("rst_acc_fir", 64'(dsp_acc_fir), 64'd0);
    lreset = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back signed beats, latency check.
    push(38'd56, 3, 1'b0);
    send(20'd2, 18'd5, 1'b0, 1'b0);
    chk("first_load_acc", 64'(dsp_load_acc), 64'd0);
    send(20'd3, 18'd6, 1'b0, 1'b0);
    chk("next_load_acc", 64'(dsp_load_acc), 64'd1);
    send(20'd4, 18'd7, 1'b0, 1'b1);
    chk("lat_e0_valid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_e1_valid", 64'(m_valid), 64'd0);
    chk("drain_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_e2_valid", 64'(m_valid), 64'd1);
    wait_done();

    // Bubbles and subtract; cfg latched on first beat only.
    cfg_unsigned_a = 1'b1;
    cfg_unsigned_b = 1'b1;
    push(38'd91, 2, 1'b0);
    send(20'd10, 18'd10, 1'b0, 1'b0);
    chk("cfg_latch_ua", 64'(dsp_unsigned_a), 64'd1);
    cfg_unsigned_a = 1'b0;
    cfg_unsigned_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bubble_dsp_a", 64'(dsp_a), 64'd0);
      chk("bubble_load_acc", 64'(dsp_load_acc), 64'd1);
    end
    send(20'd3, 18'd3, 1'b1, 1'b1);
    chk("cfg_hold_ua", 64'(dsp_unsigned_a), 64'd1);
    chk("sub_reg", 64'(dsp_subtract), 64'd1);
    wait_done();

    // Single signed negative beat.
    push(neg32, 1, 1'b0);
    send(20'hFFFFC, 18'd8, 1'b0, 1'b1);
    chk("single_load_acc", 64'(dsp_load_acc), 64'd0);
    chk("single_ua", 64'(dsp_unsigned_a), 64'd0);
    wait_done();

    // MAX_LEN truncation; fifth beat opens a new vector.
    push(38'd4, 4, 1'b1);
    for (int i = 0; i < 4; i++) send(20'd1, 18'd1, 1'b0, 1'b0);
    send(20'd1, 18'd1, 1'b0, 1'b0);
    chk("trunc_next_load_acc", 64'(dsp_load_acc), 64'd0);
    chk("trunc_q_empty", 64'(exp_q.size()), 64'd0);
    push(38'd2, 2, 1'b0);
    send(20'd1, 18'd1, 1'b0, 1'b1);
    wait_done();

    // s_last on beat MAX_LEN is not a truncation.
    push(38'd4, 4, 1'b0);
    for (int i = 0; i < 3; i++) send(20'd1, 18'd1, 1'b0, 1'b0);
    send(20'd1, 18'd1, 1'b0, 1'b1);
    wait_done();

    // Backpressure: result holds, no new beat accepted.
    m_ready = 1'b0;
    push(38'd6, 1, 1'b0);
    send(20'd2, 18'd3, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_a = 20'd7;
    s_b = 18'd1;
    s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_m_valid", 64'(m_valid), 64'd1);
      chk("bp_m_z", 64'(m_z), 64'd6);
      chk("bp_s_ready", 64'(s_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    push(38'd7, 1, 1'b0);
    @(posedge clk);
    #1;
    chk("hs_m_valid", 64'(m_valid), 64'd0);
    chk("hs_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("hs_next_load_acc", 64'(dsp_load_acc), 64'd0);
    chk("hs_next_dsp_a", 64'(dsp_a), 64'd7);
    s_valid = 1'b0;
    s_last = 1'b0;
    wait_done();

    // Async reset mid-vector discards the partial result.
    send(20'd5, 18'd5, 1'b0, 1'b0);
    send(20'd6, 18'd6, 1'b0, 1'b0);
    #2;
    lreset = 1'b0;
    #1;
    chk("arst_load_acc", 64'(dsp_load_acc), 64'd1);
    chk("arst_dsp_a", 64'(dsp_a), 64'd0);
    chk("arst_dsp_b", 64'(dsp_b), 64'd0);
    chk("arst_m_valid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    lreset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("arst_no_valid", 64'(m_valid), 64'd0);
    push(38'd1, 1, 1'b0);
    send(20'd1, 18'd1, 1'b0, 1'b1);
    wait_done();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_dsp_mac_sequencer.md
Name: rs_dsp_mac_sequencer

Overview:
- Stream-side controller that drives the control and operand pins of an RS_DSP_MULTADD instance (DSP38, MULTIPLY_ADD_SUB mode, no input or output registers).
- Accepts (a, b, sub) operand beats over valid/ready and sequences load_acc so each vector starts a fresh accumulation.
- Waits out the DSP latency, captures z and returns one dot-product result per vector over valid/ready.
- Sits between a sample/coefficient streamer and the DSP primitive.

Parameters:
- DSP_LATENCY, 1, cycles from operands on DSP pins to the accumulated result on dsp_z (1..4).
- MAX_LEN, 1024, maximum beats per vector; the vector is force-terminated at this count.
- CNT_W, 11, width of the beat counter; must satisfy 2**CNT_W > MAX_LEN.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- lreset  in  1  asynchronous, active-low reset.
- cfg_unsigned_a  in  1  operand A unsigned; sampled on the first beat of a vector.
- cfg_unsigned_b  in  1  operand B unsigned; sampled on the first beat.
- cfg_shift  in  6  output right-shift; sampled on the first beat.
- cfg_round  in  1  round enable; sampled on the first beat.
- cfg_sat  in  1  saturate enable; sampled on the first beat.
- s_valid  in  1  operand beat valid.
- s_ready  out  1  operand beat accept.
- s_a  in  20  operand A.
- s_b  in  18  operand B.
- s_sub  in  1  subtract this product from the accumulator.
- s_last  in  1  final beat of the vector.
- dsp_a  out  20  to DSP A.
- dsp_b  out  18  to DSP B.
- dsp_feedback  out  3  constant 3'b000 (accumulator feedback).
- dsp_acc_fir  out  6  constant 0.
- dsp_load_acc  out  1  0 = restart the accumulator with the product, 1 = accumulate.
- dsp_unsigned_a  out  1  latched cfg_unsigned_a.
- dsp_unsigned_b  out  1  latched cfg_unsigned_b.
- dsp_saturate  out  1  latched cfg_sat.
- dsp_shift_right  out  6  latched cfg_shift.
- dsp_round  out  1  latched cfg_round.
- dsp_subtract  out  1  registered s_sub.
- dsp_z  in  38  DSP result.
- m_valid  out  1  result valid.
- m_ready  in  1  result accept.
- m_z  out  38  captured result.
- m_count  out  CNT_W  number of beats in the vector.
- m_trunc  out  1  vector ended by MAX_LEN, not by s_last.

Behaviour:
- Reset: all outputs 0 except dsp_load_acc=1; state IDLE; counters cleared. Reset in mid-vector or mid-drain discards the partial result and emits no m_valid.
- States:
  - IDLE: s_ready=1. An accepted beat goes to ACCUM, or to DRAIN if s_last.
  - ACCUM: s_ready=1. An accepted beat with s_last, or the beat that makes count==MAX_LEN, goes to DRAIN.
  - DRAIN: s_ready=0. A timer counts 1+DSP_LATENCY cycles, then m_z<=dsp_z and the state goes to OUTPUT.
  - OUTPUT: s_ready=0, m_valid=1. On m_ready, go to IDLE.
- Operand registers: a beat accepted at edge E drives dsp_a/dsp_b/dsp_subtract after E.
  - First beat of a vector: dsp_load_acc=0. All later beats: dsp_load_acc=1.
  - The cfg_* values are latched at the first-beat edge and held until the next first beat.
- Bubbles: in any cycle without an accepted beat (ACCUM with s_valid=0, DRAIN, OUTPUT), dsp_a=0, dsp_b=0, dsp_subtract=0, dsp_load_acc=1. The zero product leaves the accumulator unchanged.
- Latency: the last beat is accepted at E0; m_z is captured at E0+1+DSP_LATENCY; m_valid is high from that edge. With DSP_LATENCY=1: 2 cycles.
- m_count = number of accepted beats, 1..MAX_LEN.
- m_trunc=1 only when MAX_LEN is reached with s_last=0. If s_last=1 on beat MAX_LEN, m_trunc=0.
- m_z, m_count and m_trunc hold stable while m_valid && !m_ready.
- No vector overlap: the next first beat is accepted no earlier than the cycle after the m_valid&&m_ready handshake.
- Arithmetic is fully delegated to the DSP; the sequencer performs no width conversion on z.

Decomposition:
- Shared package rs_dsp_mac_pkg:
  - widths A_W=20, B_W=18, Z_W=38;
  - FEEDBACK_ACC=3'b000, ACC_FIR_ZERO=6'd0;
  - state enum {IDLE, ACCUM, DRAIN, OUTPUT}.
- One sub-module, rs_dsp_mac_drain_timer: loadable down-counter; asserts done after 1+DSP_LATENCY cycles.
- The bench pairs the block with RS_DSP_MULTADD or a behavioral model of it.

Test Plan:
- Signed beats (2,5),(3,6),(4,7,last) back-to-back → m_z=56, m_count=3, m_trunc=0; m_valid 2 cycles after the last beat (DSP_LATENCY=1).
- Beats (10,10),(3,3,sub=1,last) with 3 idle cycles between them → m_z=91; dsp_load_acc=1 and dsp_a=0 during the bubbles.
- Single beat (-4,8,last), signed → m_z=-32 (38-bit two's complement), m_count=1; dsp_load_acc=0 for that beat.
- MAX_LEN=4, 5 beats of (1,1) with no last → first result m_z=4, m_trunc=1, m_count=4; beat 5 starts a new vector with load_acc=0.
- m_ready held low for 5 cycles → m_z stable, s_ready=0 throughout; the next vector's first beat is accepted the cycle after the handshake.
- lreset asserted low asynchronously after beat 2 of a 4-beat vector → outputs return to reset values immediately; no m_valid; a following vector (1,1,last) gives m_z=1.
